// File: rtl/sw_hold_ctrl.sv
// Multi-channel push-switch hold detector: each channel synchronises a switch, qualifies a
// held press of HOLD_CYC cycles and drives a level, fixed-width pulse or toggle output.
module sw_hold_ctrl #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned HOLD_CYC  = 128,
  parameter int unsigned PULSE_CYC = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [NUM_CH-1:0]     I_sw,
  input  logic [2*NUM_CH-1:0]   I_mode,
  output logic [NUM_CH-1:0]     O_out,
  output logic [NUM_CH-1:0]     O_evt,
  output logic                  O_busy
);

  localparam int unsigned PW = $clog2(PULSE_CYC + 1);

  localparam logic [CNT_W-1:0] HoldMax   = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] HitCnt    = CNT_W'(HOLD_CYC - 1);
  localparam logic [PW-1:0]    PulseLoad = PW'(PULSE_CYC);

  localparam logic [1:0] ModeLevel  = 2'b00;
  localparam logic [1:0] ModePulse  = 2'b01;
  localparam logic [1:0] ModeToggle = 2'b10;
  localparam logic [1:0] ModeOff    = 2'b11;

  if (HOLD_CYC < 1) begin : gen_hold_min_chk
    $error("HOLD_CYC must be at least 1");
  end
  if (PULSE_CYC < 1) begin : gen_pulse_min_chk
    $error("PULSE_CYC must be at least 1");
  end
  if (64'(HOLD_CYC) >= (64'd1 << CNT_W)) begin : gen_cnt_w_chk
    $error("CNT_W too narrow to hold HOLD_CYC");
  end

  logic [NUM_CH-1:0]            s1_q, s2_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][PW-1:0]    pcnt_q, pcnt_d;
  logic [NUM_CH-1:0][1:0]       mode_q, mode_d;
  logic [NUM_CH-1:0]            out_q, out_d;
  logic [NUM_CH-1:0]            evt_q, evt_d;
  logic                         busy_q, busy_d;
  logic [NUM_CH-1:0]            hit, chg;

  always_comb begin
    cnt_d  = '0;
    pcnt_d = '0;
    mode_d = '0;
    out_d  = '0;
    evt_d  = '0;
    hit    = '0;
    chg    = '0;
    busy_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy_d    = busy_d | (cnt_q[i] != '0) | (pcnt_q[i] != '0);
      mode_d[i] = I_mode[2*i +: 2];
      chg[i]    = (mode_d[i] != mode_q[i]);
      hit[i]    = s2_q[i] && (cnt_q[i] == HitCnt) && (mode_q[i] != ModeOff);
      // A mode change wipes the channel; evaluation restarts in the new mode next cycle.
      if (!chg[i] && (mode_q[i] != ModeOff)) begin
        if (s2_q[i]) begin
          cnt_d[i] = (cnt_q[i] == HoldMax) ? cnt_q[i] : cnt_q[i] + 1'b1;
        end
        evt_d[i] = hit[i];
        // A running pulse is never extended by a further hit.
        if (pcnt_q[i] != '0) begin
          pcnt_d[i] = pcnt_q[i] - 1'b1;
        end else if (hit[i] && (mode_q[i] == ModePulse)) begin
          pcnt_d[i] = PulseLoad;
        end
        unique case (mode_q[i])
          ModeLevel:  out_d[i] = s2_q[i] & (out_q[i] | hit[i]);
          ModePulse:  out_d[i] = (pcnt_d[i] != '0);
          ModeToggle: out_d[i] = out_q[i] ^ hit[i];
          default:    out_d[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cnt_q  <= '0;
      pcnt_q <= '0;
      mode_q <= '0;
      out_q  <= '0;
      evt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      s1_q   <= I_sw;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
      mode_q <= mode_d;
      out_q  <= out_d;
      evt_q  <= evt_d;
      busy_q <= busy_d;
    end
  end

  assign O_out  = out_q;
  assign O_evt  = evt_q;
  assign O_busy = busy_q;

endmodule

// File: tb/tb_sw_hold_ctrl.sv
// Bench for sw_hold_ctrl: two instances (long and short hold) driven together and compared
// every cycle against a press-length / pulse-deadline reference model, plus directed checks.
module tb_sw_hold_ctrl;

  localparam int unsigned NCH = 4;
  localparam int unsigned PC  = 16;
  localparam int unsigned HA  = 200;
  localparam int unsigned HB  = 5;

  logic              clk = 1'b0;
  logic              srst;
  logic [NCH-1:0]    sw;
  logic [2*NCH-1:0]  mode;
  logic [NCH-1:0]    out_a, evt_a, out_b, evt_b;
  logic              busy_a, busy_b;

  always #5 clk = ~clk;

  sw_hold_ctrl #(.NUM_CH(NCH), .HOLD_CYC(HA), .PULSE_CYC(PC), .CNT_W(16)) dut_a (
    .clk(clk), .srst(srst), .I_sw(sw), .I_mode(mode),
    .O_out(out_a), .O_evt(evt_a), .O_busy(busy_a)
  );

  sw_hold_ctrl #(.NUM_CH(NCH), .HOLD_CYC(HB), .PULSE_CYC(PC), .CNT_W(3)) dut_b (
    .clk(clk), .srst(srst), .I_sw(sw), .I_mode(mode),
    .O_out(out_b), .O_evt(evt_b), .O_busy(busy_b)
  );

  int    checks = 0;
  int    errors = 0;
  int    mm = 0;
  string mm_info = "";
  int    cyc = 0;

  // Reference model: run = consecutive high synchronised samples, fire on the H-th one;
  // a pulse is a deadline (edge number) before which the output stays high.
  int             hold_len [2] = '{HA, HB};
  logic           m_s1 [2][NCH];
  logic           m_s2 [2][NCH];
  int             run [2][NCH];
  int             pulse_until [2][NCH];
  logic [1:0]     m_mode [2][NCH];
  logic [NCH-1:0] e_out [2];
  logic [NCH-1:0] e_evt [2];
  logic           e_busy [2];

  task automatic tick();
    logic       b, fire;
    logic [1:0] nm;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (srst) begin
        e_busy[k] = 1'b0;
        e_out[k]  = '0;
        e_evt[k]  = '0;
        for (int i = 0; i < NCH; i++) begin
          m_s1[k][i] = 1'b0;
          m_s2[k][i] = 1'b0;
          run[k][i] = 0;
          pulse_until[k][i] = 0;
          m_mode[k][i] = 2'b00;
        end
      end else begin
        b = 1'b0;
        for (int i = 0; i < NCH; i++) begin
          b = b | (run[k][i] != 0) | (cyc - 1 < pulse_until[k][i]);
        end
        e_busy[k] = b;
        for (int i = 0; i < NCH; i++) begin
          nm = mode[2*i +: 2];
          if (nm != m_mode[k][i] || m_mode[k][i] == 2'b11) begin
            run[k][i] = 0;
            pulse_until[k][i] = 0;
            e_out[k][i] = 1'b0;
            e_evt[k][i] = 1'b0;
          end else begin
            run[k][i] = m_s2[k][i] ? run[k][i] + 1 : 0;
            fire = (run[k][i] == hold_len[k]);
            e_evt[k][i] = fire;
            case (m_mode[k][i])
              2'b00: e_out[k][i] = m_s2[k][i] & (e_out[k][i] | fire);
              2'b01: begin
                if (fire && !(cyc - 1 < pulse_until[k][i])) pulse_until[k][i] = cyc + int'(PC);
                e_out[k][i] = (cyc < pulse_until[k][i]);
              end
              default: e_out[k][i] = e_out[k][i] ^ fire;
            endcase
          end
          m_mode[k][i] = nm;
          m_s2[k][i] = m_s1[k][i];
          m_s1[k][i] = sw[i];
        end
      end
    end
    #1;
    if (out_a !== e_out[0] || evt_a !== e_evt[0] || busy_a !== e_busy[0] ||
        out_b !== e_out[1] || evt_b !== e_evt[1] || busy_b !== e_busy[1]) begin
      mm++;
      if (mm_info == "")
        mm_info = $sformatf("cyc %0d a=%b/%b/%b want %b/%b/%b b=%b/%b/%b want %b/%b/%b", cyc,
                            out_a, evt_a, busy_a, e_out[0], e_evt[0], e_busy[0],
                            out_b, evt_b, busy_b, e_out[1], e_evt[1], e_busy[1]);
    end
  endtask

  task automatic test_reset();
    int mm0;
    mm0 = mm; mm_info = "";
    srst = 1'b1; sw = '0; mode = '0;
    repeat (3) tick();
    checks++;
    if ({out_a, evt_a, busy_a, out_b, evt_b, busy_b} !== '0) begin
      errors++;
      $display("FAIL reset_state: got a=%b/%b/%b b=%b/%b/%b, want all 0",
               out_a, evt_a, busy_a, out_b, evt_b, busy_b);
    end
    sw = '1;
    repeat (3) tick();
    checks++;
    if ({out_a, evt_a, busy_a} !== '0) begin
      errors++;
      $display("FAIL reset_holds: got %b/%b/%b, want 0/0/0", out_a, evt_a, busy_a);
    end
    sw = '0;
    repeat (2) tick();
    srst = 1'b0;
    repeat (3) tick();
    checks++;
    if (mm != mm0) begin
      errors++;
      $display("FAIL reset_model: %0d cycles differ, first %s", mm - mm0, mm_info);
    end
  endtask

  task automatic test_level();
    int mm0, first, nevt;
    logic o200, o201, busy50;
    mm0 = mm; mm_info = ""; first = -1; nevt = 0;
    mode[1:0] = 2'b00;
    sw[0] = 1'b1;
    for (int e = 0; e < 2000; e++) begin
      tick();
      if (evt_a[0]) begin
        nevt++;
        if (first < 0) first = e;
      end
      if (e == 50) busy50 = busy_a;
      if (e == 200) o200 = out_a[0];
      if (e == 201) o201 = out_a[0];
    end
    checks++;
    if (first != 201) begin
      errors++; $display("FAIL level_evt_edge: got %0d, want 201", first);
    end
    checks++;
    if (nevt != 1) begin
      errors++; $display("FAIL level_evt_count: got %0d, want 1", nevt);
    end
    checks++;
    if (o200 !== 1'b0 || o201 !== 1'b1 || out_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL level_out: got e200=%b e201=%b end=%b, want 0 1 1", o200, o201, out_a[0]);
    end
    checks++;
    if (busy50 !== 1'b1) begin
      errors++; $display("FAIL level_busy: got %b, want 1", busy50);
    end
    sw[0] = 1'b0;
    tick(); tick();
    checks++;
    if (out_a[0] !== 1'b1) begin
      errors++; $display("FAIL level_release_hold: got %b, want 1", out_a[0]);
    end
    tick();
    checks++;
    if (out_a[0] !== 1'b0) begin
      errors++; $display("FAIL level_release_clear: got %b, want 0", out_a[0]);
    end
    repeat (5) tick();
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL level_model: %0d cycles differ, first %s", mm - mm0, mm_info);
    end
  endtask

  task automatic test_glitch();
    int mm0, bad, nb;
    mm0 = mm; mm_info = ""; bad = 0; nb = 0;
    mode[3:2] = 2'b00;
    for (int ph = 0; ph < 4; ph++) begin
      sw[1] = (ph % 2 == 0);
      repeat ((ph % 2 == 0) ? 150 : 5) begin
        tick();
        if (evt_a[1] || out_a[1]) bad++;
        if (evt_b[1]) nb++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL glitch_reject: got %0d active cycles, want 0", bad);
    end
    checks++;
    if (nb != 2) begin
      errors++; $display("FAIL glitch_short_hold_evts: got %0d, want 2", nb);
    end
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL glitch_model: %0d cycles differ, first %s", mm - mm0, mm_info);
    end
  endtask

  task automatic test_pulse();
    int mm0, first, nhigh, nevt_b, nhigh_b;
    logic at_first, at_end;
    mm0 = mm; mm_info = ""; first = -1; nhigh = 0; nevt_b = 0; nhigh_b = 0;
    mode[5:4] = 2'b01;
    repeat (2) tick();
    sw[2] = 1'b1;
    for (int e = 0; e < 300; e++) begin
      tick();
      if (evt_a[2] && first < 0) first = e;
      if (out_a[2]) nhigh++;
      if (e == 201) at_first = out_a[2];
      if (e == 217) at_end = out_a[2];
    end
    checks++;
    if (first != 201 || nhigh != 16) begin
      errors++; $display("FAIL pulse_width: got evt %0d width %0d, want 201 16", first, nhigh);
    end
    checks++;
    if (at_first !== 1'b1 || at_end !== 1'b0) begin
      errors++; $display("FAIL pulse_edges: got %b %b, want 1 0", at_first, at_end);
    end
    sw[2] = 1'b0;
    repeat (25) tick();
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL pulse_idle_busy: got %b %b, want 0 0", busy_a, busy_b);
    end
    // Short-hold instance: a second full press lands inside the running pulse.
    for (int ph = 0; ph < 4; ph++) begin
      sw[2] = (ph == 0 || ph == 2);
      repeat ((ph == 1) ? 2 : ((ph == 3) ? 30 : 8)) begin
        tick();
        if (evt_b[2]) nevt_b++;
        if (out_b[2]) nhigh_b++;
      end
    end
    checks++;
    if (nevt_b != 2 || nhigh_b != 16) begin
      errors++;
      $display("FAIL pulse_retrigger: got evts %0d width %0d, want 2 16", nevt_b, nhigh_b);
    end
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL pulse_model: %0d cycles differ, first %s", mm - mm0, mm_info);
    end
  endtask

  task automatic test_toggle();
    int mm0, bad, nevt;
    logic prev;
    logic [2:0] seen;
    mm0 = mm; mm_info = ""; bad = 0; nevt = 0;
    mode[7:6] = 2'b10;
    repeat (2) tick();
    prev = out_a[3];
    for (int p = 0; p < 3; p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        sw[3] = (ph == 0);
        repeat ((ph == 0) ? 250 : 20) begin
          tick();
          if (out_a[3] != prev && !evt_a[3]) bad++;
          if (evt_a[3]) nevt++;
          prev = out_a[3];
        end
        if (ph == 0) seen[p] = out_a[3];
      end
    end
    checks++;
    if (seen !== 3'b101) begin
      errors++; $display("FAIL toggle_sequence: got %b (p2..p0), want 101", seen);
    end
    checks++;
    if (bad != 0 || nevt != 3) begin
      errors++; $display("FAIL toggle_on_evt_only: got stray %0d evts %0d, want 0 3", bad, nevt);
    end
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL toggle_model: %0d cycles differ, first %s", mm - mm0, mm_info);
    end
  endtask

  task automatic test_reset_mid();
    int mm0, first;
    mm0 = mm; mm_info = ""; first = -1;
    sw[0] = 1'b1;
    repeat (100) tick();
    srst = 1'b1;
    tick();
    checks++;
    if ({out_a, evt_a, busy_a} !== '0) begin
      errors++; $display("FAIL srst_mid_clear: got %b/%b/%b, want 0", out_a, evt_a, busy_a);
    end
    srst = 1'b0;
    for (int e = 0; e < 400; e++) begin
      tick();
      if (evt_a[0] && first < 0) first = e;
    end
    checks++;
    if (first != 201) begin
      errors++; $display("FAIL srst_restart_evt: got %0d, want 201", first);
    end
    sw[0] = 1'b0;
    repeat (5) tick();
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL srst_model: %0d cycles differ, first %s", mm - mm0, mm_info);
    end
  endtask

  task automatic test_mode_change();
    int mm0, first;
    mm0 = mm; mm_info = ""; first = -1;
    sw[0] = 1'b1;
    repeat (150) tick();
    mode[1:0] = 2'b10;
    tick();
    checks++;
    if (out_a[0] !== 1'b0 || evt_a[0] !== 1'b0 || out_b[0] !== 1'b0) begin
      errors++;
      $display("FAIL mode_chg_clear: got a=%b/%b b=%b, want 0", out_a[0], evt_a[0], out_b[0]);
    end
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (evt_a[0] && first < 0) first = k;
    end
    checks++;
    if (first != 200 || out_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL mode_chg_rehold: got evt %0d out %b, want 200 1", first, out_a[0]);
    end
    mode[1:0] = 2'b00;
    tick();
    checks++;
    if (out_a[0] !== 1'b0) begin
      errors++; $display("FAIL mode_chg_back_clear: got %b, want 0", out_a[0]);
    end
    sw[0] = 1'b0;
    repeat (5) tick();
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL mode_model: %0d cycles differ, first %s", mm - mm0, mm_info);
    end
  endtask

  task automatic test_simul();
    int mm0, first;
    logic [NCH-1:0] v;
    mm0 = mm; mm_info = ""; first = -1; v = '0;
    mode = '0;
    repeat (3) tick();
    sw = '1;
    for (int e = 0; e < 260; e++) begin
      tick();
      if (evt_a != '0 && first < 0) begin
        first = e; v = evt_a;
      end
    end
    checks++;
    if (first != 201 || v !== 4'hF) begin
      errors++; $display("FAIL simul_hits: got edge %0d evt %b, want 201 1111", first, v);
    end
    sw = '0;
    repeat (5) tick();
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL simul_model: %0d cycles differ, first %s", mm - mm0, mm_info);
    end
  endtask

  task automatic test_random();
    int mm0;
    int left [NCH];
    mm0 = mm; mm_info = "";
    for (int i = 0; i < NCH; i++) left[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (left[i] == 0) begin
          sw[i] = ~sw[i];
          left[i] = $urandom_range(1, sw[i] ? 14 : 4);
        end else begin
          left[i]--;
        end
        if ($urandom_range(0, 79) == 0) mode[2*i +: 2] = 2'($urandom_range(0, 3));
      end
      srst = ($urandom_range(0, 299) == 0);
      tick();
    end
    srst = 1'b0; sw = '0; mode = '0;
    repeat (25) tick();
    checks++;
    if ({out_a, out_b, busy_a, busy_b} !== '0) begin
      errors++;
      $display("FAIL random_idle: got %b %b %b %b, want 0", out_a, out_b, busy_a, busy_b);
    end
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL random_model: %0d cycles differ, first %s", mm - mm0, mm_info);
    end
  endtask

  task automatic test_saturation();
    int mm0, nevt;
    mm0 = mm; mm_info = ""; nevt = 0;
    sw[0] = 1'b1;
    repeat (70000) begin
      tick();
      if (evt_a[0]) nevt++;
    end
    checks++;
    if (nevt != 1 || out_a[0] !== 1'b1) begin
      errors++; $display("FAIL sat_single_evt: got %0d out %b, want 1 1", nevt, out_a[0]);
    end
    checks++;
    if (dut_a.cnt_q[0] !== 16'd200 || dut_b.cnt_q[0] !== 3'd5) begin
      errors++;
      $display("FAIL sat_cnt: got %0d %0d, want 200 5", dut_a.cnt_q[0], dut_b.cnt_q[0]);
    end
    sw[0] = 1'b0;
    repeat (5) tick();
    checks++;
    if (mm != mm0) begin
      errors++; $display("FAIL sat_model: %0d cycles differ, first %s", mm - mm0, mm_info);
    end
  endtask

  initial begin
    srst = 1'b1;
    sw   = '0;
    mode = '0;
    test_reset();
    test_level();
    test_glitch();
    test_pulse();
    test_toggle();
    test_reset_mid();
    test_mode_change();
    test_simul();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
